// File: rtl/cfg_mem_write_arbiter.sv
// Arbitrates the config/readback memory write port between the SPI path and a
// buffered on-chip status writer. SPI writes always win and cancel stale entries.
module cfg_mem_write_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MEM_BYTES   = 66,
  parameter bit          DEFER_ON_SS = 1'b1
) (
  input  logic                         SCLK,
  input  logic                         RESET,
  input  logic                         SS,
  input  logic                         spi_we,
  input  logic [ADDR_W-1:0]            spi_addr,
  input  logic [DATA_W-1:0]            spi_data,
  input  logic                         int_req,
  input  logic [ADDR_W-1:0]            int_addr,
  input  logic [DATA_W-1:0]            int_data,
  output logic                         int_ready,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_data,
  output logic                         mem_src,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [7:0]                   drop_count,
  output logic                         busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0] entValid_q, entValid_d;
  logic [ADDR_W-1:0]     entAddr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     entData_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [7:0]            dropCount_q, dropCount_d;
  logic                  memWe_q, memWe_d;
  logic [ADDR_W-1:0]     memAddr_q, memAddr_d;
  logic [DATA_W-1:0]     memData_q, memData_d;
  logic                  memSrc_q, memSrc_d;

  logic       spiInRange, spiHit, spiDrop;
  logic       intInRange, push, store, pushDrop;
  logic       pop, headValid, popValid, popCancel;
  logic [1:0] dropInc;
  logic [8:0] dropSum;

  assign spiInRange = (32'(spi_addr) < MEM_BYTES);
  assign intInRange = (32'(int_addr) < MEM_BYTES);

  assign spiHit   = spi_we && spiInRange;
  assign spiDrop  = spi_we && !spiInRange;

  // Acceptance depends on occupancy only, so a full FIFO refuses a push even while popping.
  assign int_ready = (count_q < FULL_CNT);
  assign push      = int_req && int_ready;
  assign store     = push && intInRange;
  assign pushDrop  = push && !intInRange;

  assign pop       = !spi_we && (count_q != '0) && (!DEFER_ON_SS || SS);
  assign headValid = entValid_q[rdPtr_q];
  assign popValid  = pop && headValid;
  assign popCancel = pop && !headValid;

  always_comb begin
    entValid_d = entValid_q;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (spiHit && (entAddr_q[i] == spi_addr)) begin
        entValid_d[i] = 1'b0;
      end
    end
    if (pop) begin
      entValid_d[rdPtr_q] = 1'b0;
    end
    // A same-cycle push to the SPI address is born cancelled.
    if (store) begin
      entValid_d[wrPtr_q] = !(spiHit && (int_addr == spi_addr));
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (store) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    dropInc     = 2'(spiDrop) + 2'(pushDrop) + 2'(popCancel);
    dropSum     = {1'b0, dropCount_q} + 9'(dropInc);
    dropCount_d = dropSum[8] ? 8'hFF : dropSum[7:0];
  end

  // Pop never coincides with spi_we, so at most one source writes per cycle.
  always_comb begin
    memWe_d   = 1'b0;
    memAddr_d = memAddr_q;
    memData_d = memData_q;
    memSrc_d  = memSrc_q;
    if (spiHit) begin
      memWe_d   = 1'b1;
      memAddr_d = spi_addr;
      memData_d = spi_data;
      memSrc_d  = 1'b0;
    end else if (popValid) begin
      memWe_d   = 1'b1;
      memAddr_d = entAddr_q[rdPtr_q];
      memData_d = entData_q[rdPtr_q];
      memSrc_d  = 1'b1;
    end
  end

  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      entValid_q  <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dropCount_q <= '0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memData_q   <= '0;
      memSrc_q    <= 1'b0;
    end else begin
      entValid_q  <= entValid_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      dropCount_q <= dropCount_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memData_q   <= memData_d;
      memSrc_q    <= memSrc_d;
    end
  end

  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        entAddr_q[i] <= '0;
        entData_q[i] <= '0;
      end
    end else if (store) begin
      entAddr_q[wrPtr_q] <= int_addr;
      entData_q[wrPtr_q] <= int_data;
    end
  end

  assign mem_we     = memWe_q;
  assign mem_addr   = memAddr_q;
  assign mem_data   = memData_q;
  assign mem_src    = memSrc_q;
  assign fifo_count = count_q;
  assign drop_count = dropCount_q;
  assign busy       = (count_q != '0);

endmodule

// File: doc/cfg_mem_write_arbiter.md
Name: cfg_mem_write_arbiter

Overview:
Shares the single write port of the 66-byte configuration/readback memory between two requesters.
- SPI path: byte writes decoded by the SPI control logic; cannot be stalled.
- On-chip status writer: output spikes and debug snapshots written back for SPI readback.

Internal requests are buffered in a small FIFO. SPI writes always win. Pending internal writes to an address the SPI host has just written are cancelled, so the host value is never overwritten by stale on-chip data. The block sits between the SPI control logic and the memory write port, on the SCLK domain.

Parameters:
ADDR_W, 8, address width of both requesters and the memory port
DATA_W, 8, data width
FIFO_DEPTH, 4, internal-request buffer entries (power of 2, ≥2)
MEM_BYTES, 66, valid address range is 0..MEM_BYTES-1
DEFER_ON_SS, 1, if 1 the internal FIFO drains only while SS is high

Ports:
SCLK  in  1  clock; all state updates on its rising edge
RESET  in  1  asynchronous, active-high reset
SS  in  1  SPI chip select, active low
spi_we  in  1  one-cycle SPI write strobe
spi_addr  in  ADDR_W  SPI write address
spi_data  in  DATA_W  SPI write data
int_req  in  1  internal write request
int_addr  in  ADDR_W  internal write address
int_data  in  DATA_W  internal write data
int_ready  out  1  FIFO can accept an entry; a transfer occurs when int_req&&int_ready
mem_we  out  1  registered memory write enable
mem_addr  out  ADDR_W  registered memory address
mem_data  out  DATA_W  registered memory data
mem_src  out  1  0 = SPI write, 1 = internal write (valid with mem_we)
fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries, including cancelled ones
drop_count  out  8  saturating count of discarded writes
busy  out  1  fifo_count != 0

Behaviour:
Reset:
- mem_we, mem_addr, mem_data, mem_src, fifo_count, drop_count and busy are all 0.
- int_ready is 1.
- FIFO is flushed: pointers 0, all entry valid bits 0.
- Reset asserted mid-operation discards pending entries with no memory write. drop_count is cleared, not incremented.

FIFO entries:
- Each entry holds {valid, addr, data}.
- int_ready = (fifo_count < FIFO_DEPTH), derived combinationally from count only. A push in a full cycle is not accepted, even if a pop happens in the same cycle.
- On push: the entry is stored with valid=1 if int_addr < MEM_BYTES.
- If int_addr ≥ MEM_BYTES: nothing is stored and drop_count increments.

SPI path (latency 1):
- A cycle with spi_we=1 and spi_addr < MEM_BYTES gives, next cycle: mem_we=1, mem_src=0, mem_addr/mem_data = the captured values.
- If spi_addr ≥ MEM_BYTES: no write occurs and drop_count increments.

Cancellation:
- On a cycle with an in-range spi_we=1, every stored entry whose addr equals spi_addr has valid cleared.
- An entry pushed in the same cycle with int_addr == spi_addr is stored with valid=0 (SPI wins on ties).
- Each cancelled entry increments drop_count once, when it is popped.

Drain:
- The head is popped in any cycle where all of the following hold: spi_we=0, fifo_count>0, and (DEFER_ON_SS=0 or SS=1).
- Valid head: next cycle mem_we=1, mem_src=1, head addr/data.
- Invalid head: popped with mem_we=0. Cancelled entries cost one cycle each.
- At most one memory write per cycle.
- Push and pop in the same cycle leave fifo_count unchanged.

Idle outputs:
- In cycles with no write, mem_we=0. mem_addr, mem_data and mem_src hold their last values.

drop_count:
- Saturates at 255.
- Multiple drop sources in one cycle (out-of-range SPI, out-of-range push, cancelled pop) each add 1, still saturating.

Pointers:
- Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- SPI write addr 0x04 data 0x1A, SS=0, FIFO empty -> next cycle mem_we=1, mem_src=0, mem_addr=0x04, mem_data=0x1A; drop_count=0.
- SS=0, push 4 internal entries (0x10..0x13) -> int_ready=0, fifo_count=4, no mem_we. Raise SS -> four consecutive mem_we cycles, mem_src=1, addresses in order 0x10..0x13. After the last write, busy=0.
- Push addr 0x20 data 0x55 with SS=0, then SPI write to 0x20 data 0xAA, then raise SS -> only the SPI write of 0xAA occurs; the head pop produces mem_we=0; drop_count=1.
- Same-cycle int push and SPI write, both to addr 0x30 -> SPI write occurs; the entry is later dropped; drop_count=1.
- SS=1 with a continuous SPI write strobe plus one pending entry -> the internal write waits until the first cycle with spi_we=0. Out-of-range spi_addr 0x50 -> no write, drop_count increments.
- Three entries pending, assert RESET asynchronously mid-drain -> mem_we=0 immediately, fifo_count=0, int_ready=1, drop_count=0. No further writes after release.
